memory_game_core: RTL and testbench

Parametrised control and datapath core for the memory tile game. The core generates a GRID_H x GRID_W bit pattern from a seed and an increment, counts its target tiles, and optionally shows the pattern for a fixed preview window. It then runs a cursor/select play loop with lives and score. It sits between the debounced board inputs (buttons, switches) and the display/VGA top, which read the flattened pattern, mark mask, cursor and status outputs.

---
 rtl/memory_game_pkg.sv | 35 +++
 rtl/memory_row_popcount.sv | 15 +
 rtl/memory_game_core.sv | 214 +++++++++++++++++++++
 tb/tb_memory_game_core.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_game_pkg.sv
// Shared types and helpers for the memory tile game core: one-hot state
// encoding, default geometry with its derived widths, and flat tile indexing.
package memory_game_pkg;

  localparam int DEF_GRID_W     = 4;
  localparam int DEF_GRID_H     = 4;
  localparam int DEF_LIVES_INIT = 3;

  localparam int CUR_X_W = $clog2(DEF_GRID_W);
  localparam int CUR_Y_W = $clog2(DEF_GRID_H);
  localparam int REM_W   = $clog2(DEF_GRID_W * DEF_GRID_H + 1);
  localparam int LIVES_W = $clog2(DEF_LIVES_INIT + 1);

  // Bit positions of the one-hot state vector; the Q* flags are these bits.
  localparam int ST_I = 0;
  localparam int ST_G = 1;
  localparam int ST_C = 2;
  localparam int ST_V = 3;
  localparam int ST_P = 4;
  localparam int ST_L = 5;

  typedef enum logic [5:0] {
    S_INITIAL  = 6'(1 << ST_I),
    S_GENERATE = 6'(1 << ST_G),
    S_COUNT    = 6'(1 << ST_C),
    S_PREVIEW  = 6'(1 << ST_V),
    S_PLAY     = 6'(1 << ST_P),
    S_LOSE     = 6'(1 << ST_L)
  } state_t;

  function automatic int flat_idx(input int r, input int c, input int w);
    return r * w + c;
  endfunction

endpackage

// File: rtl/memory_row_popcount.sv
// Combinational popcount of one pattern row.
module memory_row_popcount #(
  parameter int W = 4
) (
  input  logic [W-1:0]           row,
  output logic [$clog2(W+1)-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++)
      count = count + ($clog2(W+1))'(row[i]);
  end

endmodule

// File: rtl/memory_game_core.sv
// Memory tile game core: pattern generation, target count, optional preview
// window (`define MEMORY_GAME_PREVIEW_EN), and the cursor/select play loop.
module memory_game_core
  import memory_game_pkg::*;
#(
  parameter int GRID_W         = DEF_GRID_W,
  parameter int GRID_H         = DEF_GRID_H,
  parameter int LIVES_INIT     = DEF_LIVES_INIT,
  parameter int SCORE_W        = 4,
  parameter int PREVIEW_CYCLES = 50_000_000
) (
  input  logic                                 Clk,
  input  logic                                 Reset,
  input  logic                                 Start,
  input  logic                                 Ack,
  input  logic [GRID_W-1:0]                    SeedIn,
  input  logic [GRID_W-1:0]                    IncIn,
  input  logic                                 Right,
  input  logic                                 Left,
  input  logic                                 Up,
  input  logic                                 Down,
  input  logic                                 Select,
  output logic [GRID_W*GRID_H-1:0]             Pattern,
  output logic [GRID_W*GRID_H-1:0]             Marked,
  output logic [$clog2(GRID_W)-1:0]            CurX,
  output logic [$clog2(GRID_H)-1:0]            CurY,
  output logic [$clog2(GRID_W*GRID_H+1)-1:0]   Remaining,
  output logic [$clog2(LIVES_INIT+1)-1:0]      Lives,
  output logic [SCORE_W-1:0]                   Score,
  output logic                                 Qi,
  output logic                                 Qg,
  output logic                                 Qc,
  output logic                                 Qv,
  output logic                                 Qp,
  output logic                                 Ql,
  output logic                                 Show
);

  localparam int N     = GRID_W * GRID_H;
  localparam int XW    = $clog2(GRID_W);
  localparam int YW    = $clog2(GRID_H);
  localparam int RW    = $clog2(N + 1);
  localparam int LW    = $clog2(LIVES_INIT + 1);
  localparam int IDXW  = $clog2(N);
  localparam int PCW   = $clog2(GRID_W + 1);
  localparam int ROW_W = (GRID_H > 1) ? $clog2(GRID_H) : 1;

  state_t            state, state_next;
  logic [GRID_W-1:0] seed, inc;
  logic [ROW_W-1:0]  row_cnt;
  logic [IDXW-1:0]   row_base, sel_idx;
  logic [GRID_W-1:0] cur_row;
  logic [PCW-1:0]    row_pop;
  logic [RW-1:0]     count_total;
  logic              last_row;
  logic [XW-1:0]     cur_x_next;
  logic [YW-1:0]     cur_y_next;

`ifdef MEMORY_GAME_PREVIEW_EN
  localparam int PVW = (PREVIEW_CYCLES > 1) ? $clog2(PREVIEW_CYCLES) : 1;
  logic [PVW-1:0] pv_cnt;
`else
  logic count_done;
`endif

  assign row_base    = IDXW'(flat_idx(int'(row_cnt), 0, GRID_W));
  assign sel_idx     = IDXW'(flat_idx(int'(CurY), int'(CurX), GRID_W));
  assign cur_row     = Pattern[row_base +: GRID_W];
  assign last_row    = (row_cnt == ROW_W'(GRID_H - 1));
  assign count_total = Remaining + RW'(row_pop);

  memory_row_popcount #(.W(GRID_W)) u_popcount (
    .row   (cur_row),
    .count (row_pop)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cur_x_next = CurX;
    cur_y_next = CurY;
    if (Right && !Left)
      cur_x_next = (CurX == XW'(GRID_W - 1)) ? '0 : CurX + 1'b1;
    else if (Left && !Right)
      cur_x_next = (CurX == '0) ? XW'(GRID_W - 1) : CurX - 1'b1;
    if (Down && !Up)
      cur_y_next = (CurY == YW'(GRID_H - 1)) ? '0 : CurY + 1'b1;
    else if (Up && !Down)
      cur_y_next = (CurY == '0) ? YW'(GRID_H - 1) : CurY - 1'b1;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_INITIAL:  if (Start) state_next = S_GENERATE;
      S_GENERATE: if (last_row) state_next = S_COUNT;
`ifdef MEMORY_GAME_PREVIEW_EN
      S_COUNT:    if (last_row) state_next = (count_total == '0) ? S_GENERATE : S_PREVIEW;
      S_PREVIEW:  if (pv_cnt == '0) state_next = S_PLAY;
`else
      S_COUNT: begin
        if (count_done) begin
          if (Start) state_next = S_PLAY;
        end else if (last_row && count_total == '0) begin
          state_next = S_GENERATE;
        end
      end
`endif
      S_PLAY: begin
        if (Remaining == '0)  state_next = S_GENERATE;
        else if (Lives == '0) state_next = S_LOSE;
      end
      S_LOSE:     if (Ack) state_next = S_INITIAL;
      default:    state_next = S_INITIAL;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (Reset) state <= S_INITIAL;
    else       state <= state_next;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      // NOTE: the pattern store is reset because the display reads it straight out of reset.
      Pattern   <= '0;
      Marked    <= '0;
      Remaining <= '0;
      Score     <= '0;
      Lives     <= LW'(LIVES_INIT);
      CurX      <= '0;
      CurY      <= '0;
      seed      <= '0;
      inc       <= '0;
      row_cnt   <= '0;
`ifdef MEMORY_GAME_PREVIEW_EN
      pv_cnt    <= '0;
`else
      count_done <= 1'b0;
`endif
    end else begin
      case (state)
        S_INITIAL: begin
          seed    <= SeedIn;
          inc     <= IncIn;
          Score   <= '0;
          Lives   <= LW'(LIVES_INIT);
          Marked  <= '0;
          CurX    <= '0;
          CurY    <= '0;
          row_cnt <= '0;
        end
        S_GENERATE: begin
          Pattern[row_base +: GRID_W] <= seed;
          seed      <= seed + inc;
          Marked    <= '0;
          Remaining <= '0;
          row_cnt   <= last_row ? '0 : row_cnt + 1'b1;
`ifndef MEMORY_GAME_PREVIEW_EN
          count_done <= 1'b0;
`endif
        end
        S_COUNT: begin
`ifdef MEMORY_GAME_PREVIEW_EN
          Remaining <= count_total;
          row_cnt   <= last_row ? '0 : row_cnt + 1'b1;
          if (last_row) pv_cnt <= PVW'(PREVIEW_CYCLES - 1);
`else
          // Once the total is in, hold the board until Start.
          if (!count_done) begin
            Remaining <= count_total;
            row_cnt   <= last_row ? '0 : row_cnt + 1'b1;
            if (last_row && count_total != '0) count_done <= 1'b1;
          end
`endif
        end
`ifdef MEMORY_GAME_PREVIEW_EN
        S_PREVIEW: if (pv_cnt != '0) pv_cnt <= pv_cnt - 1'b1;
`endif
        S_PLAY: begin
          if (Remaining == '0) begin
            if (Score != '1) Score <= Score + 1'b1;
            CurX <= '0;
            CurY <= '0;
          end else if (Lives != '0) begin
            // Select uses the cursor before this cycle's move.
            if (Select && !Marked[sel_idx]) begin
              Marked[sel_idx] <= 1'b1;
              if (Pattern[sel_idx]) Remaining <= Remaining - 1'b1;
              else                  Lives     <= Lives - 1'b1;
            end
            CurX <= cur_x_next;
            CurY <= cur_y_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign Qi = state[ST_I];
  assign Qg = state[ST_G];
  assign Qc = state[ST_C];
  assign Qp = state[ST_P];
  assign Ql = state[ST_L];
`ifdef MEMORY_GAME_PREVIEW_EN
  assign Qv   = state[ST_V];
  assign Show = state[ST_V];
`else
  assign Qv   = 1'b0;
  assign Show = 1'b0;
`endif

endmodule

// File: tb/tb_memory_game_core.sv
// Self-checking bench for memory_game_core: a rule-level game model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_memory_game_core;
  import memory_game_pkg::*;

  localparam int W = 4, H = 4, N = W * H, LIVES0 = 3, SW = 4, PC = 8;
`ifdef MEMORY_GAME_PREVIEW_EN
  localparam bit PV_EN = 1'b1;
`else
  localparam bit PV_EN = 1'b0;
`endif

  logic Clk = 1'b0, Reset = 1'b1, Start = 1'b0, Ack = 1'b0;
  logic [W-1:0] SeedIn = '0, IncIn = '0;
  logic Right = 1'b0, Left = 1'b0, Up = 1'b0, Down = 1'b0, Select = 1'b0;
  logic [N-1:0] Pattern, Marked;
  logic [CUR_X_W-1:0] CurX;
  logic [CUR_Y_W-1:0] CurY;
  logic [REM_W-1:0] Remaining;
  logic [LIVES_W-1:0] Lives;
  logic [SW-1:0] Score;
  logic Qi, Qg, Qc, Qv, Qp, Ql, Show;

  memory_game_core #(
    .GRID_W(W), .GRID_H(H), .LIVES_INIT(LIVES0), .SCORE_W(SW), .PREVIEW_CYCLES(PC)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .SeedIn(SeedIn), .IncIn(IncIn),
    .Right(Right), .Left(Left), .Up(Up), .Down(Down), .Select(Select),
    .Pattern(Pattern), .Marked(Marked), .CurX(CurX), .CurY(CurY),
    .Remaining(Remaining), .Lives(Lives), .Score(Score),
    .Qi(Qi), .Qg(Qg), .Qc(Qc), .Qv(Qv), .Qp(Qp), .Ql(Ql), .Show(Show)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0, n_pass = 0;
  bit done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- game model (rule level) ----------------
  localparam int M_INIT = 0, M_GEN = 1, M_CNT = 2, M_PV = 3, M_PLAY = 4, M_LOSE = 5;
  int mst = M_INIT;
  int m_rows[H];
  bit m_mark[H][W];
  int m_cx = 0, m_cy = 0, m_rem = 0, m_lives = LIVES0, m_score = 0;
  int m_seed = 0, m_inc = 0, m_k = 0, m_pv = 0;
  bit m_ready = 1'b0;

  task automatic clear_marks();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) m_mark[r][c] = 1'b0;
  endtask

  task automatic model_reset();
    mst = M_INIT;
    for (int r = 0; r < H; r++) m_rows[r] = 0;
    clear_marks();
    m_cx = 0; m_cy = 0; m_rem = 0; m_lives = LIVES0; m_score = 0;
    m_seed = 0; m_inc = 0; m_k = 0; m_pv = 0; m_ready = 1'b0;
  endtask

  task automatic model_step();
    case (mst)
      M_INIT: begin
        m_seed = int'(SeedIn); m_inc = int'(IncIn);
        m_score = 0; m_lives = LIVES0; clear_marks(); m_cx = 0; m_cy = 0; m_k = 0;
        if (Start) mst = M_GEN;
      end
      M_GEN: begin
        m_rows[m_k] = m_seed;
        m_seed = (m_seed + m_inc) % (1 << W);
        clear_marks(); m_rem = 0; m_ready = 1'b0;
        m_k++;
        if (m_k == H) begin m_k = 0; mst = M_CNT; end
      end
      M_CNT: begin
        if (!m_ready) begin
          m_rem += $countones(m_rows[m_k]);
          m_k++;
          if (m_k == H) begin
            m_k = 0;
            if (m_rem == 0) mst = M_GEN;
            else if (PV_EN) begin mst = M_PV; m_pv = 0; end
            else m_ready = 1'b1;
          end
        end else if (Start) begin
          mst = M_PLAY;
        end
      end
      M_PV: begin
        m_pv++;
        if (m_pv == PC) mst = M_PLAY;
      end
      M_PLAY: begin
        if (m_rem == 0) begin
          m_score = (m_score == (1 << SW) - 1) ? m_score : m_score + 1;
          m_cx = 0; m_cy = 0; mst = M_GEN;
        end else if (m_lives == 0) begin
          mst = M_LOSE;
        end else begin
          if (Select && !m_mark[m_cy][m_cx]) begin
            m_mark[m_cy][m_cx] = 1'b1;
            if (((m_rows[m_cy] >> m_cx) & 1) == 1) m_rem--;
            else m_lives--;
          end
          if (Right && !Left) m_cx = (m_cx + 1) % W;
          if (Left && !Right) m_cx = (m_cx + W - 1) % W;
          if (Down && !Up)    m_cy = (m_cy + 1) % H;
          if (Up && !Down)    m_cy = (m_cy + H - 1) % H;
        end
      end
      M_LOSE: if (Ack) mst = M_INIT;
      default: ;
    endcase
  endtask

  always @(posedge Clk or posedge Reset) begin
    if (Reset) model_reset();
    else       model_step();
  end

  function automatic logic [N-1:0] exp_pattern();
    logic [N-1:0] p = '0;
    for (int r = 0; r < H; r++) p[r*W +: W] = W'(m_rows[r]);
    return p;
  endfunction

  function automatic logic [N-1:0] exp_marked();
    logic [N-1:0] m = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) m[r*W + c] = m_mark[r][c];
    return m;
  endfunction

  always @(negedge Clk) begin
    if (!done) begin
      check("pattern",   Pattern,   exp_pattern());
      check("marked",    Marked,    exp_marked());
      check("cur_x",     CurX,      m_cx);
      check("cur_y",     CurY,      m_cy);
      check("remaining", Remaining, m_rem);
      check("lives",     Lives,     m_lives);
      check("score",     Score,     m_score);
      check("flags",     {Qi, Qg, Qc, Qv, Qp, Ql},
            {mst == M_INIT, mst == M_GEN, mst == M_CNT, mst == M_PV, mst == M_PLAY, mst == M_LOSE});
      check("show",      Show,      mst == M_PV);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic press(input bit r, input bit l, input bit u, input bit d, input bit s);
    Right = r; Left = l; Up = u; Down = d; Select = s;
    tick();
    Right = 1'b0; Left = 1'b0; Up = 1'b0; Down = 1'b0; Select = 1'b0;
  endtask

  task automatic await_play(input int budget);
    int n = 0;
    if (!PV_EN) Start = 1'b1;
    while (!Qp && n < budget) begin tick(); n++; end
    Start = 1'b0;
    check("await_play", Qp, 1);
  endtask

  task automatic start_game(input logic [W-1:0] s, input logic [W-1:0] i);
    SeedIn = s; IncIn = i; Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    check("rst_lives", Lives, 3);
    check("rst_qi", Qi, 1);
    check("rst_pattern", Pattern, 0);
    Reset = 1'b0;
    tick();

    // Seed 1, inc 1: rows 1,2,3,4 with five targets.
    start_game(4'h1, 4'h1);
    check("gen_entered", Qg, 1);
    repeat (2 * H) tick();
    check("pattern_1234", Pattern, 16'h4321);
    check("remaining_5", Remaining, 5);
`ifdef MEMORY_GAME_PREVIEW_EN
    begin
      int shown = 0, n = 0;
      while (!Qp && n < 4 * PC) begin
        if (Show) shown++;
        tick();
        n++;
      end
      check("show_cycles", shown, PC);
      check("start_to_play", 2 * H + n, 2 * H + PC);
    end
`else
    check("count_waits", Qc, 1);
    Start = 1'b1; tick(); Start = 1'b0;
    check("play_after_start", Qp, 1);
`endif

    // Cursor wrap and opposing presses.
    press(0, 1, 0, 0, 0); check("left_wrap", CurX, 3);
    press(1, 1, 0, 0, 0); check("rl_hold", CurX, 3);
    press(1, 0, 0, 0, 0); check("right_wrap", CurX, 0);
    press(0, 0, 1, 0, 0); check("up_wrap", CurY, 3);
    press(0, 0, 1, 1, 0); check("ud_hold", CurY, 3);
    press(0, 0, 0, 1, 0); check("down_wrap", CurY, 0);

    // Same target twice counts once.
    press(0, 0, 0, 0, 1); check("sel_target", Remaining, 4);
    press(0, 0, 0, 0, 1); check("sel_again", Remaining, 4);
    check("sel_again_lives", Lives, 3);

    // Clear remaining targets (1,1) (0,2) (1,2) (2,3).
    press(1, 0, 0, 1, 0); press(0, 0, 0, 0, 1);
    press(0, 1, 0, 1, 0); press(0, 0, 0, 0, 1);
    press(1, 0, 0, 0, 0); press(0, 0, 0, 0, 1);
    press(1, 0, 0, 1, 0); press(0, 0, 0, 0, 1);
    check("cleared_rem", Remaining, 0);
    tick();
    check("win_gen", Qg, 1);
    check("win_score", Score, 1);
    check("win_lives", Lives, 3);
    repeat (2 * H) tick();
    check("next_pattern", Pattern, 16'h8765);
    check("next_remaining", Remaining, 8);
    await_play(40);

    // Miss once, then reset mid-play.
    press(1, 0, 0, 0, 0);
    press(0, 0, 0, 0, 1);
    check("miss_lives", Lives, 2);
    Reset = 1'b1;
    #1;
    check("mid_rst_pattern", Pattern, 0);
    check("mid_rst_score", Score, 0);
    check("mid_rst_lives", Lives, 3);
    check("mid_rst_cur", {CurX, CurY}, 0);
    check("mid_rst_qi", Qi, 1);
    tick();
    Reset = 1'b0;
    tick();

    // Three misses: lose, Start ignored, Ack returns to INITIAL.
    start_game(4'h1, 4'h1);
    await_play(60);
    for (int i = 0; i < 3; i++) begin
      press(1, 0, 0, 0, 0);
      press(0, 0, 0, 0, 1);
    end
    check("lives_zero", Lives, 0);
    check("lose_marked", Marked, 16'h000E);
    tick();
    check("lose_state", Ql, 1);
    Start = 1'b1; tick(); Start = 1'b0;
    check("lose_ignores_start", Ql, 1);
    Ack = 1'b1; tick(); Ack = 1'b0;
    check("ack_initial", Qi, 1);

    // Empty board never becomes playable.
    begin
      int seen = 0;
      SeedIn = 4'h0; IncIn = 4'h0; Start = 1'b1;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (Qp || Qv) seen++;
      end
      Start = 1'b0;
      check("empty_never_play", seen, 0);
      check("empty_loops", Qg | Qc, 1);
    end
    Reset = 1'b1; tick(); Reset = 1'b0; tick();

    start_game(4'h0, 4'h8);
    repeat (2 * H) tick();
    check("pattern_8080", Pattern, 16'h8080);
    check("remaining_2", Remaining, 2);
    await_play(40);

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
